fifo_ctrl: RTL



---
 rtl/fifo_ctrl_pkg.sv | 24 ++
 rtl/fifo_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the FIFO controller: depth derivation,
// default thresholds and the occupancy state encoding.
package fifo_ctrl_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 2;
   localparam int DEFAULT_AE_LEVEL   = 1;

   // Number of RAM words addressed by an ADDR_WIDTH-bit pointer.
   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Default almost-full level: one word short of full.
   function automatic int default_af_level(input int addr_width);
      return fifo_depth(addr_width) - 1;
   endfunction

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_t;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving the write enable and both address
// ports of an external dual-port RAM. Tracks occupancy, publishes full/empty
// and threshold flags, and latches sticky overflow/underflow errors.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int AF_LEVEL   = default_af_level(ADDR_WIDTH),
   parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr_err,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr_wr,
   output logic [ADDR_WIDTH-1:0] addr_rd,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH        = fifo_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] LP_DEPTH_M1 = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] LP_ONE      = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] LP_AF       = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] LP_AE       = (ADDR_WIDTH+1)'(AE_LEVEL);

   occ_state_t              r_state;
   occ_state_t              w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_wr_ptr;
   logic [ADDR_WIDTH-1:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]     r_count;
   logic [ADDR_WIDTH:0]     w_count_nxt;
   logic                    r_overflow;
   logic                    r_underflow;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_wr_acc;
   logic                    w_rd_acc;
   logic                    w_ovf_evt;
   logic                    w_unf_evt;

   // Flags come straight from the registered occupancy state.
   assign w_full  = (r_state == OCC_FULL);
   assign w_empty = (r_state == OCC_EMPTY);

   // Acceptance is gated by reset so the RAM never sees a write while the
   // controller is being cleared.
   assign w_wr_acc  = wr & ~w_full  & ~reset;
   assign w_rd_acc  = rd & ~w_empty & ~reset;
   assign w_ovf_evt = wr & w_full;
   assign w_unf_evt = rd & w_empty;

   // Next occupancy state from the current state and accepted requests.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned, which would infer a latch.
      w_state_nxt = r_state;
      unique case (r_state)
         OCC_EMPTY: begin
            if (w_wr_acc)
               w_state_nxt = (DEPTH == 1) ? OCC_FULL : OCC_PARTIAL;
         end
         OCC_PARTIAL: begin
            if (w_wr_acc && !w_rd_acc && (r_count == LP_DEPTH_M1))
               w_state_nxt = OCC_FULL;
            else if (w_rd_acc && !w_wr_acc && (r_count == LP_ONE))
               w_state_nxt = OCC_EMPTY;
         end
         OCC_FULL: begin
            if (w_rd_acc)
               w_state_nxt = (DEPTH == 1) ? OCC_EMPTY : OCC_PARTIAL;
         end
         default: w_state_nxt = OCC_EMPTY;
      endcase
   end

   // Occupancy count: simultaneous accepted read and write cancel out.
   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) r_state <= OCC_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Head/tail pointers wrap naturally at DEPTH; count follows accepted ops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
      end
   end

   // Sticky error flags; a new error in the clearing cycle takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_evt)    r_overflow <= 1'b1;
         else if (clr_err) r_overflow <= 1'b0;
         if (w_unf_evt)    r_underflow <= 1'b1;
         else if (clr_err) r_underflow <= 1'b0;
      end
   end

   assign we           = w_wr_acc;
   assign addr_wr      = r_wr_ptr;
   assign addr_rd      = r_rd_ptr;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= LP_AF);
   assign almost_empty = (r_count <= LP_AE);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule : fifo_ctrl
